// File: rtl/led_seq_ctrl.sv
// LED sequencing controller: switch sync/debounce, step prescaler,
// and OFF/ON/BLINK/CHASE pattern FSM for the board LED bank.
module led_seq_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int DEBOUNCE = 480_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  output logic [2:0] led,
  output logic [1:0] mode,
  output logic       step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    ON    = 2'b01,
    BLINK = 2'b10,
    CHASE = 2'b11
  } state_t;

  state_t          state;
  state_t          nstate;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      cand;
  logic [3:0]      stable;
  logic [3:0]      prev;
  logic [DW-1:0]   dcnt;
  logic [PW-1:0]   pcnt;
  logic [2:0]      scnt;
  logic [2:0]      slast;
  logic            tick;
  logic            restart;
  logic            hit;
  logic            entry;

  always_comb begin
    slast = 3'd0;
    unique case (stable[3:2])
      2'd0: slast = 3'd0;
      2'd1: slast = 3'd1;
      2'd2: slast = 3'd3;
      2'd3: slast = 3'd7;
    endcase
  end

  assign nstate  = state_t'(stable[1:0]);
  assign tick    = (pcnt == PLAST);
  assign restart = (stable != prev);
  assign hit     = tick && (scnt == slast) && !restart;
  assign entry   = (nstate != state);
  assign mode    = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      dcnt   <= '0;
      stable <= '0;
      prev   <= '0;
    end else begin
      sync1 <= s;
      sync2 <= sync1;
      prev  <= stable;
      if (sync2 != cand) begin
        cand <= sync2;
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        stable <= cand;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Any change of the accepted switches restarts step timing from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
      scnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
      scnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
      scnt <= (scnt == slast) ? 3'd0 : scnt + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= OFF;
      led   <= '0;
      step  <= 1'b0;
    end else begin
      state <= nstate;
      step  <= hit;
      unique case (nstate)
        OFF: led <= 3'b000;
        ON:  led <= 3'b111;
        BLINK: begin
          if (entry)    led <= 3'b111;
          else if (hit) led <= ~led;
        end
        CHASE: begin
          if (entry)    led <= 3'b001;
          else if (hit) led <= {led[1:0], led[2]};
        end
      endcase
    end
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

LED sequencing controller for the board LED bank. It synchronizes and debounces the four slide switches, then decodes them into an LED mode and a step rate. A prescaler divides the onboard oscillator into step events, and an FSM drives three registered LED outputs as OFF, ON, BLINK or a one-hot CHASE pattern. It sits between the switch pins and the LED pins, next to the existing `led_display` logic, and supplies the oscillator-timed LED behaviour.

## Interface
- `TICK_DIV`, 10_000_000: oscillator cycles per base tick. At 48 MHz HSOSC, rate 0 blinks at 2.4 Hz.
- `DEBOUNCE`, 480_000: cycles the synchronized switch vector must hold steady before it is accepted (10 ms at 48 MHz). Must be ≥ 1.
- `clk` in 1: oscillator clock; everything is in this domain.
- `reset` in 1: synchronous, active-low reset. All state clears on any rising `clk` edge that samples `reset`=0.
- `s` in 4: raw, asynchronous switches. `s[1:0]` selects the mode; `s[3:2]` selects the rate.
- `led` out 3: registered LED drive, active-high.
- `mode` out 2: current FSM state (00 OFF, 01 ON, 10 BLINK, 11 CHASE).
- `step` out 1: one-cycle pulse, registered, coincident with every pattern advance.

## Operation
- **Synchronizer:** two flops, `s` → `sync1` → `sync2`, both reset to 0.
- **Debounce (whole 4-bit vector):**
  - If `sync2` ≠ `cand`: `cand`←`sync2`, `dcnt`←0.
  - Else if `dcnt`==`DEBOUNCE`-1: `stable`←`cand` and `dcnt` holds.
  - Else `dcnt`++.
  - `cand`, `dcnt` and `stable` all reset to 0.
- **Rate:** `r` = `stable[3:2]`. A step occurs every (`TICK_DIV` << `r`) cycles, so `r` = 0,1,2,3 gives 1×, 2×, 4×, 8× the tick.
- **Prescaler:** `pcnt` counts 0..`TICK_DIV`-1 and wraps. `tick` is combinational, high when `pcnt`==`TICK_DIV`-1.
- **Step counter:** `scnt` counts ticks 0..(1<<`r`)-1. The step condition is `tick` && `scnt`==(1<<`r`)-1, at which point `scnt` wraps to 0.
- **Restart:** a restart is any cycle in which `stable` differs from its value on the previous cycle. On restart, `pcnt`←0, `scnt`←0, and the step condition is suppressed that cycle.
- **FSM:** the next state is always `stable[1:0]`; there are no other transitions. A state change happens on the edge after `stable` changes. The entry actions below apply on that edge.
  - OFF: `led`=000.
  - ON: `led`=111.
  - BLINK: on entry `led`=111. Each step inverts all three bits.
  - CHASE: on entry `led`=001. Each step rotates left: 001→010→100→001.
- **Rate change within BLINK/CHASE:** a change to `stable[3:2]` alone keeps the current `led` pattern; only the timing restarts.
- **`step` output:** asserted for exactly one cycle on every step condition, in every mode, including OFF and ON where `led` does not change.

## Timing
- **Reset values:** `led`=000, `mode`=00, `step`=0; all counters and flops 0. The first step comes `TICK_DIV` cycles after reset release.
- **Switch-to-LED latency:** the `s` change is sampled at edge k.
  - `sync2` updates at k+1.
  - `cand` updates at k+2.
  - `stable` updates at k+2+`DEBOUNCE`.
  - `mode`/`led` update at k+3+`DEBOUNCE`.
- **Glitch rejection:** a `sync2` pulse shorter than `DEBOUNCE`+1 cycles never reaches `stable`.
- **Step timing:** `step` and the `led` advance register on the same edge, the one that samples the step condition.
  - After a restart at edge e, the first step registers at edge e+(`TICK_DIV`<<`r`).
  - Later steps follow every (`TICK_DIV`<<`r`) cycles with no drift.
- **Simultaneous events:** a restart and a step condition in the same cycle resolve as restart: no step, counters cleared.
- **Reset mid-pattern:** reset overrides everything, including the debounce and synchronizer state.
- **Counter widths:** `pcnt` is $clog2(`TICK_DIV`) bits; `scnt` is 3 bits; `dcnt` is $clog2(`DEBOUNCE`) bits (minimum 1). No counter may overflow at its terminal value.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE`=3.
1. Reset held with `s`=0110, then released → `led`=000 and `mode`=00 while reset is held; `mode`=10 and `led`=111 exactly 6 edges after the first post-release edge.
2. BLINK with `r`=1 → `led` toggles 111→000→111 every 8 cycles, with a one-cycle `step` on each toggle.
3. `s`=1111 (CHASE, `r`=3) → `led` goes 001, 010, 100, 001 at 32-cycle spacing; `mode`=11.
4. A 2-cycle pulse 0010→0011→0010 on `s` during BLINK → `stable`, `mode` and `led` phase are unaffected, and `step` spacing is unchanged.
5. Rate change 0010→0110 during BLINK, one cycle before a due step → no step that cycle, the `led` value is kept, and the next toggle comes 8 cycles after the restart.
6. `reset`=0 for one edge mid-CHASE → `led`=000, `mode`=00 and `step`=0 on the next cycle; CHASE resumes at 001 after the debounce latency.
